alu_mdu: RTL

- Parametrised successor to the single-cycle combinational ALU in the execute stage.
- Adds RV32M multiply/divide through an iterative radix-2 datapath.
- Wraps all ops in a valid/ready handshake with a registered result, so the pipeline can stall on multi-cycle ops.
- Sits between operand-forwarding muxes and the EX/MEM register; the hazard unit stalls on o_ready low or o_valid low.

---
 rtl/alu_mdu.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/alu_mdu.sv
// alu_mdu: execute-stage ALU with iterative RV32M multiply/divide behind a
// valid/ready handshake. Single-cycle ops and divide special cases
// resolve at accept; MUL*/DIV*/REM* iterate DATA_W cycles on magnitudes.
module alu_mdu #(
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [4:0]        i_alu_op,
  input  logic [DATA_W-1:0] i_operand_a,
  input  logic [DATA_W-1:0] i_operand_b,
  input  logic              i_flush,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_alu_data,
  output logic              o_busy
);

  localparam int SHAMT_W = $clog2(DATA_W);
  localparam int CNT_W   = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic [4:0] {
    OP_ADD = 5'd0, OP_SUB = 5'd1, OP_SLL = 5'd2, OP_SLT = 5'd3, OP_SLTU = 5'd4,
    OP_XOR = 5'd5, OP_SRL = 5'd6, OP_SRA = 5'd7, OP_OR = 5'd8, OP_AND = 5'd9,
    OP_MUL = 5'd10, OP_MULH = 5'd11, OP_MULHSU = 5'd12, OP_MULHU = 5'd13,
    OP_DIV = 5'd14, OP_DIVU = 5'd15, OP_REM = 5'd16, OP_REMU = 5'd17
  } op_t;

  state_t state, state_n;
  op_t    op;

  logic [DATA_W-1:0]  a, b;
  logic [SHAMT_W-1:0] shamt;
  logic               accept, is_mul, is_divop, b_zero, overflow, special, iterative;
  logic               a_signed, b_signed, a_neg, b_neg;
  logic [DATA_W-1:0]  mag_a, mag_b, single_res;

  // iteration state: hi = running product high half / partial remainder,
  // lo = multiplier being consumed / dividend shifting into quotient
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] hi, lo, opnd;
  logic              is_div, sel_hi, neg_lo, neg_rem;
  logic [DATA_W-1:0] hi_n, lo_n, final_res;

  assign op     = op_t'(i_alu_op);
  assign a      = i_operand_a;
  assign b      = i_operand_b;
  assign shamt  = b[SHAMT_W-1:0];
  assign accept = i_valid && (state == IDLE) && !i_flush;

  // op classification, special-case detection and operand magnitudes
  always_comb begin
    is_mul    = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU);
    is_divop  = (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
    b_zero    = (b == '0);
    overflow  = (a == {1'b1, {(DATA_W-1){1'b0}}}) && (b == '1) && ((op == OP_DIV) || (op == OP_REM));
    special   = is_divop && (b_zero || overflow);
    iterative = is_mul || (is_divop && !special);
    a_signed  = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    b_signed  = (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    a_neg     = a_signed && a[DATA_W-1];
    b_neg     = b_signed && b[DATA_W-1];
    mag_a     = a_neg ? -a : a;
    mag_b     = b_neg ? -b : b;
  end

  // single-cycle results, including divide-by-zero and signed-overflow cases
  always_comb begin
    single_res = '0;
    case (op)
      OP_ADD:  single_res = a + b;
      OP_SUB:  single_res = a - b;
      OP_SLL:  single_res = a << shamt;
      OP_SLT:  single_res = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: single_res = {{(DATA_W-1){1'b0}}, (a < b)};
      OP_XOR:  single_res = a ^ b;
      OP_SRL:  single_res = a >> shamt;
      OP_SRA:  single_res = $signed(a) >>> shamt;
      OP_OR:   single_res = a | b;
      OP_AND:  single_res = a & b;
      OP_DIV, OP_DIVU: single_res = b_zero ? '1 : a;
      OP_REM, OP_REMU: single_res = b_zero ? a : '0;
      default: single_res = '0;
    endcase
  end

  // one radix-2 step: shift-add for multiply, restore-subtract for divide;
  // sign fix applied to the post-step value so the last step writes the result
  logic [DATA_W:0]     add, shifted, sub;
  logic [2*DATA_W-1:0] prod, prod_fix;
  logic [DATA_W-1:0]   quo, rem;
  always_comb begin
    add      = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    shifted  = {hi, lo[DATA_W-1]};
    sub      = shifted - {1'b0, opnd};
    if (is_div) begin
      hi_n = sub[DATA_W] ? shifted[DATA_W-1:0] : sub[DATA_W-1:0];
      lo_n = {lo[DATA_W-2:0], ~sub[DATA_W]};
    end else begin
      hi_n = add[DATA_W:1];
      lo_n = {add[0], lo[DATA_W-1:1]};
    end
    prod     = {hi_n, lo_n};
    prod_fix = neg_lo ? -prod : prod;
    quo      = neg_lo ? -lo_n : lo_n;
    rem      = neg_rem ? -hi_n : hi_n;
    if (is_div) final_res = sel_hi ? rem : quo;
    else        final_res = sel_hi ? prod_fix[2*DATA_W-1:DATA_W] : prod_fix[DATA_W-1:0];
  end

  // state register
  always_ff @(posedge i_clk) begin
    if (i_reset) state <= IDLE;
    else         state <= state_n;
  end

  // next-state logic; flush overrides everything
  always_comb begin
    state_n = state;
    if (i_flush) state_n = IDLE;
    else begin
      case (state)
        IDLE:    if (accept) state_n = iterative ? BUSY : DONE;
        BUSY:    if (count == CNT_W'(1)) state_n = DONE;
        DONE:    if (i_ready) state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  // handshake outputs decoded from state
  always_comb begin
    o_ready = (state == IDLE);
    o_valid = (state == DONE);
    o_busy  = (state == BUSY);
  end

  // operand capture, iteration and result register; flush freezes the datapath
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_alu_data <= '0;
      count      <= '0;
      hi         <= '0;
      lo         <= '0;
      opnd       <= '0;
      is_div     <= 1'b0;
      sel_hi     <= 1'b0;
      neg_lo     <= 1'b0;
      neg_rem    <= 1'b0;
    end else if (!i_flush) begin
      if (accept) begin
        if (iterative) begin
          count   <= CNT_W'(DATA_W);
          hi      <= '0;
          lo      <= is_divop ? mag_a : mag_b;
          opnd    <= is_divop ? mag_b : mag_a;
          is_div  <= is_divop;
          sel_hi  <= is_divop ? ((op == OP_REM) || (op == OP_REMU)) : (op != OP_MUL);
          neg_lo  <= a_neg ^ b_neg;
          neg_rem <= a_neg;
        end else begin
          o_alu_data <= single_res;
        end
      end else if (state == BUSY) begin
        hi    <= hi_n;
        lo    <= lo_n;
        count <= count - CNT_W'(1);
        if (count == CNT_W'(1)) o_alu_data <= final_res;
      end
    end
  end

endmodule
